// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count,
// "all off" patterns for the active-low pins and the hex segment table.
package sseg_pkg;

    localparam int NDIG = 4;

    // Active-low: a one turns a segment/anode off.
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Segment codes in a..g order (bit 6 = a, bit 0 = g), active-low.
    // Ascending index range so the leftmost literal is entry 0.
    localparam logic [0:15][6:0] SEG_CODE = {
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] hex);
        return SEG_CODE[hex];
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern.
// seg_o[0] is segment a, seg_o[6] is segment g.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [0:6] seg_o
);

    // Table bit 6 (segment a) lands on seg_o[0].
    assign seg_o = seg_lookup(hex_i);

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode scan driver. A divider paces digit slots, the
// display word is latched only at frame start so digits never tear, and
// SSeg/An/frame are registered so the pins change only on slot boundaries.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int DIV_CNT = 50000,
    parameter bit LZB     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*NDIG-1:0]     num,
    input  logic                  upd,
    input  logic [NDIG-1:0]       blank,
    output logic [0:6]            SSeg,
    output logic [NDIG-1:0]       An,
    output logic                  frame
);

    localparam int DIV_W = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);

    logic [DIV_W-1:0]  div_q,   div_d;
    logic [1:0]        idx_q,   idx_d;
    logic [4*NDIG-1:0] disp_q,  disp_d;
    logic              pend_q,  pend_d;
    logic [0:6]        seg_q,   seg_d;
    logic [NDIG-1:0]   an_q,    an_d;
    logic              frame_q, frame_d;

    logic              tick;
    logic              frame_start;
    logic              load;
    logic [3:0]        nib;
    logic [0:6]        dec_seg;
    logic [NDIG-1:0]   lz_mask;
    logic              digit_off;

    // Leading-zero mask for the word that will be on display after this
    // cycle: digit k is suppressible when nibbles k..3 are all zero.
    // Digit 0 always shows, so a zero word still reads "0".
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_lz
            if (gi == 0) begin : g_first
                assign lz_mask[gi] = 1'b0;
            end else begin : g_upper
                assign lz_mask[gi] = LZB && (disp_d[4*NDIG-1:4*gi] == '0);
            end
        end
    endgenerate

    // Decode the nibble for the slot being entered, using the value being
    // loaded this cycle so a fresh word shows on digit 0 immediately.
    assign nib = disp_d[{idx_d, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .hex_i (nib),
        .seg_o (dec_seg)
    );

    // Next-state logic for divider, index, update latch and output registers.
    always_comb begin
        tick        = (div_q == DIV_LAST);
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        frame_start = tick && (idx_q == 2'd3);
        // A request in the loading cycle itself is consumed by this load.
        load        = frame_start && (pend_q || upd);
        disp_d      = load ? num : disp_q;
        pend_d      = load ? 1'b0 : (pend_q || upd);

        // blank is sampled only here, so a mid-slot change waits for the tick.
        digit_off   = blank[idx_d] || lz_mask[idx_d];

        seg_d       = seg_q;
        an_d        = an_q;
        if (tick) begin
            seg_d = digit_off ? SEG_OFF : dec_seg;
            an_d  = digit_off ? AN_OFF  : ~(NDIG'(1) << idx_d);
        end
        frame_d     = frame_start;
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            idx_q   <= 2'd3;
            disp_q  <= '0;
            pend_q  <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign SSeg  = seg_q;
    assign An    = an_q;
    assign frame = frame_q;

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Downstream display stage for the 8×4 register bank. It takes the 16-bit display word built from the bank's read ports, latches it on frame boundaries so digits never tear, and time-multiplexes four common-anode seven-segment digits. It generates the `SSeg`/`An` pins the board drives, with per-digit blanking and optional leading-zero suppression.

## Interface
- `DIV_CNT`, default 50000: clock cycles per digit slot (50 MHz gives 1 kHz per digit). Must be ≥ 2.
- `LZB`, default 0: 1 enables leading-zero suppression.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. `rst=0` clears the block.
- `num` in 16: display word. Nibble 3 feeds digit 3 (leftmost) and nibble 0 feeds digit 0.
- `upd` in 1: update request, level-sampled every cycle.
- `blank` in 4: per-digit force-off mask, sampled live.
- `SSeg` out [0:6]: segments a..g, active-low. `SSeg[0]=a` and `SSeg[6]=g`.
- `An` out 4: digit anodes, active-low. `An[0]` is digit 0.
- `frame` out 1: one-cycle pulse when digit 0 is selected (frame start).

## Operation
- **Divider:** `div_q` counts 0..`DIV_CNT`-1 and wraps. `tick` is asserted for the one cycle where `div_q`=`DIV_CNT`-1.
- **Digit index:** `idx_q` (2 bits) advances on `tick`, 3→0 wrap, giving the sequence 0,1,2,3,0,…
- **Update latch:**
  - `upd`=1 sets `pend_q`.
  - On a `tick` whose next index is 0: if `pend_q`|`upd`, then `disp_q`←`num` (value in that cycle) and `pend_q`←0.
  - `upd` arriving in the same cycle as the loading tick is consumed by that load; `pend_q` stays 0.
  - `num` changes with no `upd` are never displayed.
- **Decode** (hex, active-low, a..g order):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- **Blanking:** digit k is blank if `blank[k]`, or if `LZB`=1 and k>0 and all nibbles k..3 of `disp_q` are 0. Digit 0 is never LZB-blanked.
  - A blank digit drives `An`=1111 and `SSeg`=1111111 for its slot (slot time is still consumed).
- **Outputs:** `SSeg`, `An` and `frame` are registered. They load on `tick` with values computed for the new index. Between ticks they hold.
  - Non-blank slot: `An` = one-hot-low of the index.
  - Exactly one anode is low at most at any time.

## Timing
- **Reset (async, `rst`=0):** `div_q`=0, `idx_q`=3, `disp_q`=0, `pend_q`=0, `An`=1111, `SSeg`=1111111, `frame`=0.
- **First slot:** the first `tick` occurs `DIV_CNT` cycles after reset release. Its registered outputs are visible on the following edge, selecting digit 0 with `frame`=1 for one cycle.
- **Slot timing:** each slot lasts exactly `DIV_CNT` cycles. A full frame is 4·`DIV_CNT` cycles.
- **Update latency:**
  - A loaded value appears on digit 0 in the same edge as the load.
  - Worst-case `upd`→visible latency is 4·`DIV_CNT`+1 cycles.
- **Mid-frame `blank` change:** takes effect at the next `tick`. It is not glitch-applied within a slot.
- **Reset mid-frame:** outputs go off immediately, asynchronously. `pend_q` and `disp_q` are lost, and the restart is identical to power-up.

## Structure
- **Package `sseg_pkg`:**
  - 16-entry segment code constant.
  - `SEG_OFF`=7'b1111111 and `AN_OFF`=4'b1111.
  - `NDIG`=4.
- **Sub-module `hex_to_sseg`:** combinational, 4-bit in, [0:6] out.
- **`sseg_scan_driver`:** contains the divider, index, latch, blanking and output registers.

## Test plan
All scenarios use `DIV_CNT`=4.
- **Reset and first frame:** hold `rst`=0, then release with `num`=16'h0000, `upd`=0 → `An`=1111 and `SSeg`=1111111 until the first tick. Then digit 0 shows 0000001 with `An`=1110 and `frame`=1 for one cycle. Slots follow every 4 cycles in the order 1110,1101,1011,0111.
- **Update latch:** `num`=16'h5B61, `upd` pulsed 1 cycle mid-frame → no change until the next frame start. Then digits 0..3 show 1001111 (1), 0100000 (6), 1100000 (b), 0100100 (5).
- **No-update isolation:** `num` changes to 16'hFFFF with `upd`=0 → the display still shows 5B61 for ≥3 frames.
- **Simultaneous `upd` and frame tick:** assert `upd` exactly in the tick cycle with `num`=16'h00A0 → the load happens at that frame. `pend_q` is 0 afterwards and there is no reload next frame.
- **Blanking:**
  - `LZB`=1 with `disp_q`=16'h00A0 → digits 3 and 2 have `An`=1111. Digit 1 shows 0001000 and digit 0 shows 0000001.
  - `blank`=4'b0001 → digit 0 slot is also dark.
- **Async reset mid-slot:** assert `rst`=0 two cycles into the digit 2 slot → `An`=1111 with no clock edge. After release, the first frame repeats exactly, showing 0000.
